led_strip_sequencer: RTL and testbench
======================================

LED_STRIP_SEQUENCER -- requirements
Module: led_strip_sequencer

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- T0H_CYC, 10: high-phase cycles for a 0 bit.
- T1H_CYC, 20: high-phase cycles for a 1 bit.
- BIT_CYC, 32: total cycles per bit period (HIGH + LOW).
- LATCH_CYC, 1400: low cycles for the strip latch/reset gap (56 us at 25 MHz).
- N_LEDS, 8: frames expected per refresh.

REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk, in, 1: single clock, rising edge.
- rst, in, 1: reset, synchronous and active-high.
- start, in, 1: pulse that requests one refresh.
- busy, out, 1: high from acceptance of start until LATCH completes.
- done, out, 1: one-cycle pulse on the last LATCH cycle.
- seq_err, out, 1: sticky flag for a frame-count mismatch.
- led_dout, out, 1: serial strip data line.
- new_bit_rqst, out, 1: one-cycle pulse that shifts the transmitter to its next bit.
- new_frame_rqst, out, 1: one-cycle pulse that loads the next 24-bit frame.
- bit_to_transmit, in, 1: current bit from the transmitter.
- all_bits_shifted, in, 1: current frame is exhausted.
- new_frames_set_rqst, in, 1: all frames of the set have been sent.

Function
REQ-003 The FSM SHALL have five states: IDLE, HIGH, LOW, LOAD, LATCH.
REQ-004 In IDLE, start=1 SHALL move the FSM to HIGH, clear bit_cnt and frame_cnt, and set busy=1 at the next edge.
REQ-005 start SHALL be ignored while busy=1.
REQ-006 bit_cnt SHALL count 0..BIT_CYC-1, with width $clog2(BIT_CYC).
REQ-007 At bit_cnt=0, bit_to_transmit SHALL be captured into cur_bit.
REQ-008 new_bit_rqst SHALL pulse in the bit_cnt=1 cycle, exactly once per bit.
REQ-009 led_dout SHALL be 1 while bit_cnt < (cur_bit ? T1H_CYC : T0H_CYC), with bit_cnt=0 driven from the captured-value path; led_dout SHALL be 0 otherwise.
- The HIGH-to-LOW state change SHALL coincide with the fall of led_dout.
REQ-010 At bit_cnt=BIT_CYC-1, all_bits_shifted and new_frames_set_rqst SHALL be sampled.
- all_bits_shifted=0: go to HIGH with bit_cnt=0.
- all_bits_shifted=1: go to LOAD.
REQ-011 LOAD SHALL last 1 cycle, with new_frame_rqst=1, led_dout=0, and frame_cnt+1.
- Next state is LATCH if the sampled new_frames_set_rqst was 1, otherwise HIGH.
REQ-012 If frame_cnt reaches N_LEDS in LOAD while the sampled new_frames_set_rqst=0, the FSM SHALL set seq_err=1 and go to LATCH.
REQ-013 If new_frames_set_rqst=1 is sampled while frame_cnt+1 != N_LEDS, the FSM SHALL set seq_err=1 and still go to LATCH.
REQ-014 LATCH SHALL hold led_dout=0 for exactly LATCH_CYC cycles, then pulse done, clear busy, and go to IDLE (or HIGH, see REQ-019).
REQ-015 new_bit_rqst and new_frame_rqst SHALL never be high in the same cycle, and neither SHALL be high in IDLE or LATCH.

Reset
REQ-016 rst=1 at a rising edge SHALL force state=IDLE, led_dout=0, busy=0, done=0, seq_err=0, new_bit_rqst=0, new_frame_rqst=0, and bit_cnt=frame_cnt=latch_cnt=0 at that edge, in any state, including mid-bit.
REQ-017 start asserted in the same cycle as rst SHALL be ignored.
REQ-018 seq_err SHALL be cleared only by rst.

Configuration
REQ-019 Macro LED_SEQ_AUTO_REFRESH_EN SHALL control auto-refresh.
- Defined: at LATCH end, the FSM pulses done, stays busy=1, clears frame_cnt, and goes to HIGH without start; it reaches IDLE only via rst.
- Undefined: LATCH ends in IDLE per REQ-014, and refresh is start-driven only.

Verification
REQ-020 Scenario 1: rst, then a start pulse with a transmitter model on 8 frames of 0x111111.
- Required: 192 bit periods of 32 cycles, with a high time of 10 cycles for 0 bits and 20 cycles for 1 bits.
- Required: 192 new_bit_rqst pulses, 8 new_frame_rqst pulses, then 1400 low cycles, done=1 once, and seq_err=0.
REQ-021 Scenario 2: start asserted again at cycle 100 of a refresh -> no restart, and the pulse counts are identical to Scenario 1.
REQ-022 Scenario 3: rst asserted in a bit's HIGH phase at bit_cnt=5 -> led_dout=0 and busy=0 on the next edge, with no further rqst pulses.
REQ-023 Scenario 4: model asserts new_frames_set_rqst after frame 5 (6 frames sent) -> seq_err=1, LATCH entered, and done pulses.
- Model never asserts new_frames_set_rqst -> seq_err=1 after 8 LOADs.
REQ-024 Scenario 5: build with LED_SEQ_AUTO_REFRESH_EN and a single start -> two consecutive refreshes separated by exactly 1400 low cycles, done pulsing each time, and busy staying 1.

Source files
------------

// File: rtl/led_strip_sequencer.sv
// led_strip_sequencer: bit/frame/latch timing for a single-wire addressable LED strip.
// It steps an external shift-register transmitter through 24-bit frames, one bit period
// at a time, and closes each refresh with a long low latch gap.
// Optional feature: define LED_SEQ_AUTO_REFRESH_EN to restart a new refresh
// automatically after every latch gap. In that build only rst returns the block to IDLE.
module led_strip_sequencer #(
    parameter int T0H_CYC   = 10,
    parameter int T1H_CYC   = 20,
    parameter int BIT_CYC   = 32,
    parameter int LATCH_CYC = 1400,
    parameter int N_LEDS    = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    output logic busy,
    output logic done,
    output logic seq_err,
    output logic led_dout,
    output logic new_bit_rqst,
    output logic new_frame_rqst,
    input  logic bit_to_transmit,
    input  logic all_bits_shifted,
    input  logic new_frames_set_rqst
);

    localparam int BW = $clog2(BIT_CYC);
    localparam int FW = $clog2(N_LEDS + 1);
    localparam int LW = $clog2(LATCH_CYC);

    localparam logic [BW-1:0] C_T0H_LAST   = BW'(T0H_CYC - 1);
    localparam logic [BW-1:0] C_T1H_LAST   = BW'(T1H_CYC - 1);
    localparam logic [BW-1:0] C_BIT_LAST   = BW'(BIT_CYC - 1);
    localparam logic [BW-1:0] C_BIT_ONE    = BW'(1);
    localparam logic [FW-1:0] C_N_LEDS     = FW'(N_LEDS);
    localparam logic [FW-1:0] C_FRAME_ONE  = FW'(1);
    localparam logic [LW-1:0] C_LATCH_LAST = LW'(LATCH_CYC - 1);
    localparam logic [LW-1:0] C_LATCH_ONE  = LW'(1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_HIGH  = 3'd1,
        S_LOW   = 3'd2,
        S_LOAD  = 3'd3,
        S_LATCH = 3'd4
    } state_t;

    state_t        r_state,     w_state_next;
    logic [BW-1:0] r_bit_cnt,   w_bit_cnt_next;
    logic [FW-1:0] r_frame_cnt, w_frame_cnt_next;
    logic [LW-1:0] r_latch_cnt, w_latch_cnt_next;
    logic          r_cur_bit,   w_cur_bit_next;
    logic          r_set_seen,  w_set_seen_next;
    logic          r_seq_err,   w_seq_err_next;
    logic          r_busy;
    logic          r_led_dout;

    // In the first cycle of a bit the captured register is not loaded yet, so the
    // high-time threshold is taken straight from the transmitter input.
    logic          w_eff_bit;
    logic [BW-1:0] w_high_last;
    logic [FW-1:0] w_frame_inc;

    assign w_eff_bit   = (r_bit_cnt == '0) ? bit_to_transmit : r_cur_bit;
    assign w_high_last = w_eff_bit ? C_T1H_LAST : C_T0H_LAST;
    assign w_frame_inc = r_frame_cnt + C_FRAME_ONE;

    assign busy           = r_busy;
    assign led_dout       = r_led_dout;
    assign seq_err        = r_seq_err;
    assign done           = (r_state == S_LATCH) && (r_latch_cnt == C_LATCH_LAST);
    assign new_bit_rqst   = (r_state == S_HIGH) && (r_bit_cnt == C_BIT_ONE);
    assign new_frame_rqst = (r_state == S_LOAD);

    // Next-state and counter logic for the bit/frame/latch sequence.
    always_comb begin
        w_state_next     = r_state;
        w_bit_cnt_next   = r_bit_cnt;
        w_frame_cnt_next = r_frame_cnt;
        w_latch_cnt_next = r_latch_cnt;
        w_cur_bit_next   = r_cur_bit;
        w_set_seen_next  = r_set_seen;
        w_seq_err_next   = r_seq_err;

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_next     = S_HIGH;
                    w_bit_cnt_next   = '0;
                    w_frame_cnt_next = '0;
                end
            end
            S_HIGH: begin
                if (r_bit_cnt == '0) begin
                    w_cur_bit_next = bit_to_transmit;
                end
                w_bit_cnt_next = r_bit_cnt + C_BIT_ONE;
                if (r_bit_cnt == w_high_last) begin
                    w_state_next = S_LOW;
                end
            end
            S_LOW: begin
                if (r_bit_cnt == C_BIT_LAST) begin
                    w_bit_cnt_next  = '0;
                    w_set_seen_next = new_frames_set_rqst;
                    w_state_next    = all_bits_shifted ? S_LOAD : S_HIGH;
                end else begin
                    w_bit_cnt_next = r_bit_cnt + C_BIT_ONE;
                end
            end
            S_LOAD: begin
                w_frame_cnt_next = w_frame_inc;
                if (r_set_seen) begin
                    // End of set: the frame count must match the strip length.
                    w_state_next = S_LATCH;
                    if (w_frame_inc != C_N_LEDS) begin
                        w_seq_err_next = 1'b1;
                    end
                end else if (w_frame_inc == C_N_LEDS) begin
                    // Strip is full but the transmitter still claims more frames.
                    w_state_next   = S_LATCH;
                    w_seq_err_next = 1'b1;
                end else begin
                    w_state_next = S_HIGH;
                end
            end
            S_LATCH: begin
                if (r_latch_cnt == C_LATCH_LAST) begin
                    w_latch_cnt_next = '0;
`ifdef LED_SEQ_AUTO_REFRESH_EN
                    w_state_next     = S_HIGH;
                    w_bit_cnt_next   = '0;
                    w_frame_cnt_next = '0;
`else
                    w_state_next     = S_IDLE;
`endif
                end else begin
                    w_latch_cnt_next = r_latch_cnt + C_LATCH_ONE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // State, counters and registered outputs; reset wins over everything, including start.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_bit_cnt   <= '0;
            r_frame_cnt <= '0;
            r_latch_cnt <= '0;
            r_cur_bit   <= 1'b0;
            r_set_seen  <= 1'b0;
            r_seq_err   <= 1'b0;
            r_busy      <= 1'b0;
            r_led_dout  <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_bit_cnt   <= w_bit_cnt_next;
            r_frame_cnt <= w_frame_cnt_next;
            r_latch_cnt <= w_latch_cnt_next;
            r_cur_bit   <= w_cur_bit_next;
            r_set_seen  <= w_set_seen_next;
            r_seq_err   <= w_seq_err_next;
            r_busy      <= (w_state_next != S_IDLE);
            r_led_dout  <= (w_state_next == S_HIGH);
        end
    end

endmodule

// File: tb/tb_led_strip_sequencer.sv
// Testbench for led_strip_sequencer: a shift-register transmitter model feeds random
// frames, and every refresh is compared cycle by cycle against a timeline built from
// the bit/frame/latch timing rules. Build with LED_SEQ_AUTO_REFRESH_EN to check auto-refresh.
module tb_led_strip_sequencer;

    localparam int T0H   = 10;
    localparam int T1H   = 20;
    localparam int BITC  = 32;
    localparam int LATCH = 1400;
    localparam int NL    = 8;

    logic clk = 1'b0;
    logic rst, start, busy, done, seq_err, led_dout, new_bit_rqst, new_frame_rqst;
    logic bit_to_transmit, all_bits_shifted, new_frames_set_rqst;

    int n_vec = 0;
    int n_bad = 0;
    logic exp_err = 1'b0;

    always #5 clk = ~clk;

    led_strip_sequencer #(
        .T0H_CYC(T0H), .T1H_CYC(T1H), .BIT_CYC(BITC), .LATCH_CYC(LATCH), .N_LEDS(NL)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .start               (start),
        .busy                (busy),
        .done                (done),
        .seq_err             (seq_err),
        .led_dout            (led_dout),
        .new_bit_rqst        (new_bit_rqst),
        .new_frame_rqst      (new_frame_rqst),
        .bit_to_transmit     (bit_to_transmit),
        .all_bits_shifted    (all_bits_shifted),
        .new_frames_set_rqst (new_frames_set_rqst)
    );

    // Transmitter model: 24-bit frames sent MSB first; set_at = frames in the set (0 = never ends).
    logic [23:0] frames [NL];
    int   tx_f = 0;
    int   tx_b = 0;
    int   set_at = NL;
    logic tx_clr = 1'b1;

    always @(posedge clk) begin
        if (tx_clr) begin
            tx_f <= 0;
            tx_b <= 0;
        end else if (new_frame_rqst) begin
            tx_b <= 0;
            tx_f <= (tx_f == NL - 1 || tx_f == set_at - 1) ? 0 : tx_f + 1;
        end else if (new_bit_rqst) begin
            tx_b <= tx_b + 1;
        end
    end

    always_comb begin
        logic [23:0] cur;
        cur                 = frames[tx_f % NL];
        all_bits_shifted    = (tx_b >= 24);
        bit_to_transmit     = 1'b0;
        if (tx_b < 24) bit_to_transmit = cur[23 - tx_b];
        new_frames_set_rqst = all_bits_shifted && (set_at > 0) && (tx_f == set_at - 1);
    end

    // Expected per-cycle outputs {busy, led_dout, new_bit_rqst, new_frame_rqst, done}.
    logic [4:0] exp_q [$];

    task automatic build_timeline(input int nf, input int n_ref);
        logic [23:0] fr;
        int hi;
        exp_q.delete();
        for (int r = 0; r < n_ref; r++) begin
            for (int k = 0; k < nf; k++) begin
                fr = frames[k];
                for (int j = 0; j < 24; j++) begin
                    hi = fr[23 - j] ? T1H : T0H;
                    for (int c = 0; c < BITC; c++)
                        exp_q.push_back({1'b1, (c < hi), (c == 1), 1'b0, 1'b0});
                end
                exp_q.push_back(5'b10010);
            end
            for (int c = 0; c < LATCH; c++)
                exp_q.push_back({1'b1, 1'b0, 1'b0, 1'b0, (c == LATCH - 1)});
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; start = 1'b0; tx_clr = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; tx_clr = 1'b0;
        exp_err = 1'b0;
    endtask

    task automatic randomize_frames();
        for (int k = 0; k < NL; k++) frames[k] = 24'($urandom);
    endtask

    // One start-driven refresh (or n_ref back-to-back in the auto build), checked cycle by cycle.
    task automatic run_refresh(input string name, input int s_at, input int restart_at, input int n_ref);
        int nf, bad_cyc, first_bad, n_bit, n_frm, n_done, last_frm_i, done_i;
        logic [4:0] obs, first_obs, first_exp;
        set_at = s_at;
        nf = (s_at > 0 && s_at < NL) ? s_at : NL;
        if (s_at != NL) exp_err = 1'b1;
        build_timeline(nf, n_ref);
        tx_clr = 1'b1;
        @(posedge clk); #1;
        tx_clr = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        bad_cyc = 0; first_bad = -1; n_bit = 0; n_frm = 0; n_done = 0;
        last_frm_i = -1; done_i = -1; first_obs = '0; first_exp = '0;
        for (int i = 0; i < exp_q.size(); i++) begin
            obs = {busy, led_dout, new_bit_rqst, new_frame_rqst, done};
            if (obs !== exp_q[i]) begin
                if (first_bad < 0) begin
                    first_bad = i; first_obs = obs; first_exp = exp_q[i];
                end
                bad_cyc++;
            end
            if (new_bit_rqst === 1'b1) n_bit++;
            if (new_frame_rqst === 1'b1) begin
                n_frm++;
                if (done_i < 0) last_frm_i = i;
            end
            if (done === 1'b1) begin
                n_done++;
                if (done_i < 0) done_i = i;
            end
            start = (i == restart_at);
            @(posedge clk); #1;
        end
        start = 1'b0;

        n_vec++;
        if (bad_cyc !== 0) begin
            n_bad++;
            $display("FAIL %s.timeline: %0d bad cycles, first at %0d got %b expected %b",
                     name, bad_cyc, first_bad, first_obs, first_exp);
        end
        n_vec++;
        if (n_bit !== nf * 24 * n_ref) begin
            n_bad++;
            $display("FAIL %s.bit_rqst_count: got %0d expected %0d", name, n_bit, nf * 24 * n_ref);
        end
        n_vec++;
        if (n_frm !== nf * n_ref) begin
            n_bad++;
            $display("FAIL %s.frame_rqst_count: got %0d expected %0d", name, n_frm, nf * n_ref);
        end
        n_vec++;
        if (n_done !== n_ref) begin
            n_bad++;
            $display("FAIL %s.done_count: got %0d expected %0d", name, n_done, n_ref);
        end
        n_vec++;
        if (done_i - last_frm_i !== LATCH) begin
            n_bad++;
            $display("FAIL %s.latch_len: got %0d expected %0d", name, done_i - last_frm_i, LATCH);
        end
        n_vec++;
        if (seq_err !== exp_err) begin
            n_bad++;
            $display("FAIL %s.seq_err: got %b expected %b", name, seq_err, exp_err);
        end
`ifdef LED_SEQ_AUTO_REFRESH_EN
        n_vec++;
        if ({busy, led_dout} !== 2'b11) begin
            n_bad++;
            $display("FAIL %s.after_latch: busy,dout got %b expected 11", name, {busy, led_dout});
        end
        do_reset();
`else
        n_vec++;
        if ({busy, led_dout} !== 2'b00) begin
            n_bad++;
            $display("FAIL %s.after_latch: busy,dout got %b expected 00", name, {busy, led_dout});
        end
`endif
        $display("%s: %0d frames x %0d, %0d bit rqst, %0d frame rqst, %0d done, seq_err=%b",
                 name, nf, n_ref, n_bit, n_frm, n_done, seq_err);
    endtask

    task automatic test_reset();
        logic [5:0] obs;
        rst = 1'b1; start = 1'b0; tx_clr = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        obs = {busy, done, seq_err, led_dout, new_bit_rqst, new_frame_rqst};
        n_vec++;
        if (obs !== 6'b0) begin
            n_bad++;
            $display("FAIL reset.in_reset: outputs got %b expected 000000", obs);
        end
        rst = 1'b0; tx_clr = 1'b0;
        @(posedge clk); #1;
        obs = {busy, done, seq_err, led_dout, new_bit_rqst, new_frame_rqst};
        n_vec++;
        if (obs !== 6'b0) begin
            n_bad++;
            $display("FAIL reset.after_release: outputs got %b expected 000000", obs);
        end
        $display("reset: outputs %b", obs);
    endtask

    task automatic test_refresh_pattern();
        for (int k = 0; k < NL; k++) frames[k] = 24'h111111;
        run_refresh("refresh_0x111111", NL, -1, 1);
    endtask

    task automatic test_start_ignored();
        randomize_frames();
        run_refresh("start_while_busy", NL, 100, 1);
    endtask

    task automatic test_set_early();
        randomize_frames();
        run_refresh("set_after_6_frames", 6, -1, 1);
    endtask

    task automatic test_err_sticky();
        randomize_frames();
        run_refresh("err_sticky_refresh", NL, -1, 1);
    endtask

    task automatic test_no_set();
        randomize_frames();
        run_refresh("set_never", 0, -1, 1);
    endtask

    task automatic test_mid_bit_reset();
        int n_pulse, n_high, n_busy;
        randomize_frames();
        set_at = NL;
        tx_clr = 1'b1;
        @(posedge clk); #1;
        tx_clr = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        // Cycle 101 is bit 3 of frame 0 with the bit counter at 5, still in the high phase.
        repeat (101) @(posedge clk);
        #1;
        n_vec++;
        if (led_dout !== 1'b1) begin
            n_bad++;
            $display("FAIL mid_bit_reset.pre_high: led_dout got %b expected 1", led_dout);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; exp_err = 1'b0;
        n_vec++;
        if ({led_dout, busy, seq_err} !== 3'b000) begin
            n_bad++;
            $display("FAIL mid_bit_reset.next_edge: dout,busy,seq_err got %b expected 000",
                     {led_dout, busy, seq_err});
        end
        n_pulse = 0; n_high = 0; n_busy = 0;
        for (int i = 0; i < 100; i++) begin
            if (new_bit_rqst === 1'b1 || new_frame_rqst === 1'b1 || done === 1'b1) n_pulse++;
            if (led_dout === 1'b1) n_high++;
            if (busy === 1'b1) n_busy++;
            @(posedge clk); #1;
        end
        n_vec++;
        if ({n_pulse, n_high, n_busy} !== 96'd0) begin
            n_bad++;
            $display("FAIL mid_bit_reset.quiet: pulses %0d high %0d busy %0d expected 0 0 0",
                     n_pulse, n_high, n_busy);
        end
        $display("mid_bit_reset: pulses %0d high %0d busy %0d", n_pulse, n_high, n_busy);
    endtask

    task automatic test_reset_with_start();
        int n_busy;
        rst = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; start = 1'b0; exp_err = 1'b0;
        n_busy = 0;
        for (int i = 0; i < 20; i++) begin
            if (busy === 1'b1 || led_dout === 1'b1) n_busy++;
            @(posedge clk); #1;
        end
        n_vec++;
        if (n_busy !== 0) begin
            n_bad++;
            $display("FAIL reset_with_start.busy_cycles: got %0d expected 0", n_busy);
        end
        $display("reset_with_start: busy/high cycles %0d", n_busy);
    endtask

`ifdef LED_SEQ_AUTO_REFRESH_EN
    task automatic test_auto_refresh();
        randomize_frames();
        run_refresh("auto_refresh_x2", NL, -1, 2);
    endtask
`else
    task automatic test_idle_after_latch();
        int n_busy;
        randomize_frames();
        run_refresh("idle_after_latch", NL, -1, 1);
        n_busy = 0;
        for (int i = 0; i < 50; i++) begin
            if (busy === 1'b1 || led_dout === 1'b1 || new_bit_rqst === 1'b1) n_busy++;
            @(posedge clk); #1;
        end
        n_vec++;
        if (n_busy !== 0) begin
            n_bad++;
            $display("FAIL idle_after_latch.stays_idle: active cycles %0d expected 0", n_busy);
        end
        $display("idle_after_latch: active cycles %0d", n_busy);
    endtask
`endif

    initial begin
        rst = 1'b1; start = 1'b0;
        for (int k = 0; k < NL; k++) frames[k] = 24'h0;
        test_reset();
        test_refresh_pattern();
        test_start_ignored();
        test_set_early();
        test_err_sticky();
        test_mid_bit_reset();
        test_no_set();
        test_reset_with_start();
`ifdef LED_SEQ_AUTO_REFRESH_EN
        test_auto_refresh();
`else
        test_idle_after_latch();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
